// File: rtl/psum_acc_pkg.sv
// Shared state encoding, default lane widths and saturation bounds for psum_accumulator.
package psum_acc_pkg;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ACCUM = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;

    localparam int DEF_IN_W  = 5;
    localparam int DEF_OUT_W = 16;

    function automatic longint sat_max(input int w);
        return (64'sd1 <<< (w - 1)) - 64'sd1;
    endfunction

    function automatic longint sat_min(input int w);
        return -(64'sd1 <<< (w - 1));
    endfunction

endpackage

// File: rtl/psum_lane_acc.sv
// One lane: load on the first beat, saturating add on later beats, per-beat clamp flag.
// With PSUM_ACC_RELU_EN defined, the final beat of a group stores max(result, 0).
module psum_lane_acc
    import psum_acc_pkg::*;
#(
    parameter int IN_W  = DEF_IN_W,
    parameter int OUT_W = DEF_OUT_W
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    beat,
    input  logic                    first,
    input  logic                    last,
    input  logic signed [IN_W-1:0]  psum,
    output logic signed [OUT_W-1:0] acc,
    output logic                    sat
);

    localparam logic signed [OUT_W:0] MAX_W = (OUT_W+1)'(sat_max(OUT_W));
    localparam logic signed [OUT_W:0] MIN_W = (OUT_W+1)'(sat_min(OUT_W));

    logic signed [OUT_W:0]   psum_x;
    logic signed [OUT_W:0]   acc_x;
    logic signed [OUT_W:0]   sum_p0;
    logic signed [OUT_W-1:0] next_p0;

    function automatic logic signed [OUT_W-1:0] clamp(input logic signed [OUT_W:0] s);
        if (s > MAX_W) return MAX_W[OUT_W-1:0];
        if (s < MIN_W) return MIN_W[OUT_W-1:0];
        return s[OUT_W-1:0];
    endfunction

    function automatic logic signed [OUT_W-1:0] relu(input logic signed [OUT_W-1:0] v);
`ifdef PSUM_ACC_RELU_EN
        return v[OUT_W-1] ? '0 : v;
`else
        return v;
`endif
    endfunction

    // Sum is formed one bit wider than the accumulator so overflow is visible before clamping.
    always_comb begin
        psum_x  = {{(OUT_W+1-IN_W){psum[IN_W-1]}}, psum};
        acc_x   = {acc[OUT_W-1], acc};
        sum_p0  = first ? psum_x : acc_x + psum_x;
        next_p0 = clamp(sum_p0);
        if (last) next_p0 = relu(next_p0);
        sat     = beat && ((sum_p0 > MAX_W) || (sum_p0 < MIN_W));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    acc <= '0;
        else if (beat) acc <= next_p0;
    end

endmodule

// File: rtl/psum_accumulator.sv
// Accumulates num_pass psum beats per lane into one saturated result per group.
// Optional ReLU on the stored result is enabled by defining PSUM_ACC_RELU_EN.
module psum_accumulator
    import psum_acc_pkg::*;
#(
    parameter int LANES = 256,
    parameter int IN_W  = DEF_IN_W,
    parameter int OUT_W = DEF_OUT_W,
    parameter int CNT_W = 8,
    parameter int GRP_W = 12
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [CNT_W-1:0]       num_pass,
    input  logic [GRP_W-1:0]       num_groups,
    input  logic [IN_W*LANES-1:0]  psum_in,
    input  logic                   psum_valid,
    output logic                   psum_ready,
    output logic [OUT_W*LANES-1:0] acc_out,
    output logic                   acc_valid,
    input  logic                   acc_ready,
    output logic                   acc_last,
    output logic                   busy,
    output logic                   done,
    output logic                   sat_flag
);

    logic [1:0]       state;
    logic [1:0]       state_nx;
    logic [CNT_W-1:0] pass_cnt;
    logic [CNT_W-1:0] pass_max;
    logic [GRP_W-1:0] grp_cnt;
    logic             done_zero;
    logic             beat;
    logic             first;
    logic             last_beat;
    logic             final_grp;
    logic             out_hs;
    logic             accept;
    logic [LANES-1:0] lane_sat;

    assign beat      = psum_valid & psum_ready;
    assign first     = (pass_cnt == '0);
    assign last_beat = (pass_cnt == pass_max - CNT_W'(1));
    assign final_grp = (grp_cnt == GRP_W'(1));
    assign out_hs    = acc_valid & acc_ready;
    assign accept    = (state == IDLE) && start && (num_groups != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept) state_nx = ACCUM;
            ACCUM:   if (beat && last_beat) state_nx = DRAIN;
            DRAIN:   if (acc_ready) state_nx = final_grp ? IDLE : ACCUM;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        psum_ready = (state == ACCUM);
        acc_valid  = (state == DRAIN);
        acc_last   = (state == DRAIN) && final_grp;
        busy       = (state != IDLE);
        done       = done_zero || ((state == DRAIN) && acc_ready && final_grp);
    end

    // An empty job still owes the caller a done pulse, one cycle after start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pass_cnt  <= '0;
            pass_max  <= '0;
            grp_cnt   <= '0;
            done_zero <= 1'b0;
            sat_flag  <= 1'b0;
        end else begin
            done_zero <= (state == IDLE) && start && (num_groups == '0);
            if (accept) begin
                pass_max <= (num_pass == '0) ? CNT_W'(1) : num_pass;
                grp_cnt  <= num_groups;
                pass_cnt <= '0;
                sat_flag <= 1'b0;
            end else begin
                if (beat)      pass_cnt <= pass_cnt + CNT_W'(1);
                if (|lane_sat) sat_flag <= 1'b1;
                if (out_hs) begin
                    pass_cnt <= '0;
                    grp_cnt  <= grp_cnt - GRP_W'(1);
                end
            end
        end
    end

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        psum_lane_acc #(
            .IN_W  (IN_W),
            .OUT_W (OUT_W)
        ) u_lane (
            .clk   (clk),
            .rst_n (rst_n),
            .beat  (beat),
            .first (first),
            .last  (last_beat),
            .psum  (psum_in[g*IN_W +: IN_W]),
            .acc   (acc_out[g*OUT_W +: OUT_W]),
            .sat   (lane_sat[g])
        );
    end

endmodule

// File: tb/tb_psum_accumulator.sv
// Randomized bench for psum_accumulator against an integer reference model of per-group saturating sums.
`timescale 1ns/1ps
module tb_psum_accumulator;

    localparam int LANES = 4;
    localparam int IN_W  = 5;
    localparam int OUT_W = 8;
    localparam int CNT_W = 8;
    localparam int GRP_W = 12;
    localparam int LIM   = 200;
    localparam int VMAX  = 2**(OUT_W-1) - 1;
    localparam int VMIN  = -(2**(OUT_W-1));

    typedef int beat_t [LANES];

    logic                   clk;
    logic                   rst_n;
    logic                   start;
    logic [CNT_W-1:0]       num_pass;
    logic [GRP_W-1:0]       num_groups;
    logic [IN_W*LANES-1:0]  psum_in;
    logic                   psum_valid;
    logic                   psum_ready;
    logic [OUT_W*LANES-1:0] acc_out;
    logic                   acc_valid;
    logic                   acc_ready;
    logic                   acc_last;
    logic                   busy;
    logic                   done;
    logic                   sat_flag;

    int total = 0;
    int bad   = 0;
    int m_acc [LANES];
    bit m_sat;

    psum_accumulator #(
        .LANES (LANES), .IN_W (IN_W), .OUT_W (OUT_W), .CNT_W (CNT_W), .GRP_W (GRP_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .num_pass   (num_pass),
        .num_groups (num_groups),
        .psum_in    (psum_in),
        .psum_valid (psum_valid),
        .psum_ready (psum_ready),
        .acc_out    (acc_out),
        .acc_valid  (acc_valid),
        .acc_ready  (acc_ready),
        .acc_last   (acc_last),
        .busy       (busy),
        .done       (done),
        .sat_flag   (sat_flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int post(input int x);
`ifdef PSUM_ACC_RELU_EN
        return (x < 0) ? 0 : x;
`else
        return x;
`endif
    endfunction

    function automatic int lane_out(input int i);
        logic signed [OUT_W-1:0] v;
        v = acc_out[i*OUT_W +: OUT_W];
        return int'(v);
    endfunction

    // Reference: a group's value is its first beat plus each later beat, clamped after every add.
    task automatic model_beat(input beat_t v, input bit first);
        int s;
        for (int i = 0; i < LANES; i++) begin
            if (first) begin
                m_acc[i] = v[i];
            end else begin
                s = m_acc[i] + v[i];
                if (s > VMAX) begin s = VMAX; m_sat = 1'b1; end
                if (s < VMIN) begin s = VMIN; m_sat = 1'b1; end
                m_acc[i] = s;
            end
        end
    endtask

    task automatic rnd(output beat_t v);
        for (int i = 0; i < LANES; i++) v[i] = int'($urandom_range(0, 31)) - 16;
    endtask

    task automatic do_start(input int np, input int ng);
        start      = 1'b1;
        num_pass   = CNT_W'(np);
        num_groups = GRP_W'(ng);
        if (ng != 0) m_sat = 1'b0;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic feed(input beat_t v, input bit first);
        int n;
        n = 0;
        for (int i = 0; i < LANES; i++) psum_in[i*IN_W +: IN_W] = IN_W'(v[i]);
        psum_valid = 1'b1;
        while (!psum_ready && n < LIM) begin @(negedge clk); n++; end
        if (!psum_ready) begin
            total++; bad++;
            $display("FAIL feed_timeout psum_ready=%0b required=1", psum_ready);
        end
        @(negedge clk);
        psum_valid = 1'b0;
        model_beat(v, first);
    endtask

    task automatic take(output beat_t got, output bit lst, output bit dn);
        int n;
        n = 0;
        while (!acc_valid && n < LIM) begin @(negedge clk); n++; end
        if (!acc_valid) begin
            total++; bad++;
            $display("FAIL take_timeout acc_valid=%0b required=1", acc_valid);
        end
        acc_ready = 1'b1;
        #1;
        for (int i = 0; i < LANES; i++) got[i] = lane_out(i);
        lst = acc_last;
        dn  = done;
        @(negedge clk);
        acc_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; num_pass = '0; num_groups = '0;
        psum_in = '0; psum_valid = 1'b0; acc_ready = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if ({acc_valid, acc_last, psum_ready, busy, done, sat_flag} !== 6'b0) begin
            bad++;
            $display("FAIL reset_ctrl got=%b required=000000",
                     {acc_valid, acc_last, psum_ready, busy, done, sat_flag});
        end
        total++;
        if (acc_out !== '0) begin bad++; $display("FAIL reset_acc_out got=%h required=0", acc_out); end
        rst_n = 1'b1;
        @(negedge clk);
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL reset_idle busy=%0b required=0", busy); end
    endtask

    task automatic test_basic();
        beat_t got;
        bit lst, dn;
        do_start(3, 1);
        feed('{5, -1, 0, 0}, 1);
        feed('{7, -1, 0, 0}, 0);
        feed('{-3, -1, 0, 0}, 0);
        total++;
        if (acc_valid !== 1'b1) begin bad++; $display("FAIL basic_latency acc_valid=%0b required=1", acc_valid); end
        take(got, lst, dn);
        total++;
        if (got[0] !== post(9)) begin bad++; $display("FAIL basic_lane0 got=%0d required=%0d", got[0], post(9)); end
        total++;
        if (got[1] !== post(-3)) begin bad++; $display("FAIL basic_lane1 got=%0d required=%0d", got[1], post(-3)); end
        total++;
        if ({lst, dn} !== 2'b11) begin bad++; $display("FAIL basic_last_done got=%b required=11", {lst, dn}); end
        total++;
        if ({busy, sat_flag} !== 2'b00) begin bad++; $display("FAIL basic_idle_sat got=%b required=00", {busy, sat_flag}); end
    endtask

    task automatic test_saturation();
        beat_t got;
        bit lst, dn;
        do_start(12, 1);
        for (int k = 0; k < 12; k++) feed('{15, 0, 0, 0}, k == 0);
        take(got, lst, dn);
        total++;
        if (got[0] !== post(VMAX)) begin bad++; $display("FAIL sat_pos got=%0d required=%0d", got[0], post(VMAX)); end
        total++;
        if (sat_flag !== 1'b1) begin bad++; $display("FAIL sat_flag_pos got=%0b required=1", sat_flag); end
        do_start(10, 1);
        total++;
        if (sat_flag !== 1'b0) begin bad++; $display("FAIL sat_clear got=%0b required=0", sat_flag); end
        for (int k = 0; k < 10; k++) feed('{0, -16, 0, 0}, k == 0);
        take(got, lst, dn);
        total++;
        if (got[1] !== post(VMIN)) begin bad++; $display("FAIL sat_neg got=%0d required=%0d", got[1], post(VMIN)); end
        total++;
        if (sat_flag !== 1'b1) begin bad++; $display("FAIL sat_flag_neg got=%0b required=1", sat_flag); end
    endtask

    task automatic test_backpressure();
        beat_t b, got;
        bit lst, dn;
        logic [OUT_W*LANES-1:0] snap;
        do_start(2, 2);
        rnd(b); feed(b, 1);
        rnd(b); feed(b, 0);
        snap = acc_out;
        for (int c = 0; c < 5; c++) begin
            rnd(b);
            for (int i = 0; i < LANES; i++) psum_in[i*IN_W +: IN_W] = IN_W'(b[i]);
            psum_valid = 1'b1;
            @(negedge clk);
            total++;
            if ({acc_valid, psum_ready, acc_last} !== 3'b100 || acc_out !== snap) begin
                bad++;
                $display("FAIL bp_hold cycle=%0d vld_rdy_last=%b out=%h required=100 out=%h",
                         c, {acc_valid, psum_ready, acc_last}, acc_out, snap);
            end
        end
        psum_valid = 1'b0;
        take(got, lst, dn);
        for (int i = 0; i < LANES; i++) begin
            total++;
            if (got[i] !== post(m_acc[i])) begin
                bad++; $display("FAIL bp_grp0_lane%0d got=%0d required=%0d", i, got[i], post(m_acc[i]));
            end
        end
        total++;
        if ({lst, dn} !== 2'b00) begin bad++; $display("FAIL bp_grp0_last got=%b required=00", {lst, dn}); end
        rnd(b); feed(b, 1);
        rnd(b); feed(b, 0);
        take(got, lst, dn);
        for (int i = 0; i < LANES; i++) begin
            total++;
            if (got[i] !== post(m_acc[i])) begin
                bad++; $display("FAIL bp_grp1_lane%0d got=%0d required=%0d", i, got[i], post(m_acc[i]));
            end
        end
        total++;
        if ({lst, dn} !== 2'b11) begin bad++; $display("FAIL bp_grp1_last got=%b required=11", {lst, dn}); end
    endtask

    task automatic test_num_pass_zero();
        beat_t b, got;
        bit lst, dn;
        do_start(0, 3);
        for (int g = 0; g < 3; g++) begin
            rnd(b); feed(b, 1);
            total++;
            if (acc_valid !== 1'b1) begin bad++; $display("FAIL np0_valid grp=%0d got=%0b required=1", g, acc_valid); end
            take(got, lst, dn);
            for (int i = 0; i < LANES; i++) begin
                total++;
                if (got[i] !== post(b[i])) begin
                    bad++; $display("FAIL np0_lane%0d grp=%0d got=%0d required=%0d", i, g, got[i], post(b[i]));
                end
            end
            total++;
            if (lst !== (g == 2)) begin bad++; $display("FAIL np0_last grp=%0d got=%0b required=%0b", g, lst, g == 2); end
        end
    endtask

    task automatic test_num_groups_zero();
        start = 1'b1; num_pass = CNT_W'(3); num_groups = '0;
        @(negedge clk);
        start = 1'b0;
        total++;
        if ({done, busy} !== 2'b10) begin bad++; $display("FAIL ng0_done got=%b required=10", {done, busy}); end
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            total++;
            if ({done, acc_valid, busy} !== 3'b000) begin
                bad++; $display("FAIL ng0_quiet cycle=%0d got=%b required=000", c, {done, acc_valid, busy});
            end
        end
    endtask

    task automatic test_start_busy();
        beat_t b, got;
        bit lst, dn;
        do_start(2, 1);
        rnd(b); feed(b, 1);
        start = 1'b1; num_pass = CNT_W'(5); num_groups = GRP_W'(7);
        @(negedge clk);
        start = 1'b0;
        rnd(b); feed(b, 0);
        total++;
        if (acc_valid !== 1'b1) begin bad++; $display("FAIL busy_start_valid got=%0b required=1", acc_valid); end
        take(got, lst, dn);
        for (int i = 0; i < LANES; i++) begin
            total++;
            if (got[i] !== post(m_acc[i])) begin
                bad++; $display("FAIL busy_start_lane%0d got=%0d required=%0d", i, got[i], post(m_acc[i]));
            end
        end
        total++;
        if ({lst, dn, busy} !== 3'b110) begin bad++; $display("FAIL busy_start_end got=%b required=110", {lst, dn, busy}); end
    endtask

    task automatic test_reset_mid_job();
        beat_t b, got;
        bit lst, dn;
        do_start(4, 1);
        rnd(b); feed(b, 1);
        rnd(b); feed(b, 0);
        rst_n = 1'b0;
        #1;
        total++;
        if ({acc_valid, acc_last, psum_ready, busy, done, sat_flag} !== 6'b0 || acc_out !== '0) begin
            bad++;
            $display("FAIL midrst_outputs ctrl=%b out=%h required=000000 out=0",
                     {acc_valid, acc_last, psum_ready, busy, done, sat_flag}, acc_out);
        end
        @(negedge clk);
        rst_n = 1'b1;
        m_sat = 1'b0;
        @(negedge clk);
        do_start(4, 1);
        for (int k = 0; k < 4; k++) feed('{1, 1, 1, 1}, k == 0);
        take(got, lst, dn);
        for (int i = 0; i < LANES; i++) begin
            total++;
            if (got[i] !== 4) begin bad++; $display("FAIL midrst_lane%0d got=%0d required=4", i, got[i]); end
        end
        total++;
        if ({lst, dn, sat_flag} !== 3'b110) begin bad++; $display("FAIL midrst_end got=%b required=110", {lst, dn, sat_flag}); end
    endtask

    task automatic test_random();
        beat_t b, got;
        bit lst, dn;
        int np, ng, eff;
        for (int j = 0; j < 8; j++) begin
            np  = int'($urandom_range(0, 12));
            ng  = int'($urandom_range(1, 3));
            eff = (np == 0) ? 1 : np;
            do_start(np, ng);
            for (int g = 0; g < ng; g++) begin
                for (int k = 0; k < eff; k++) begin
                    repeat ($urandom_range(0, 2)) @(negedge clk);
                    rnd(b); feed(b, k == 0);
                end
                repeat ($urandom_range(0, 3)) @(negedge clk);
                take(got, lst, dn);
                for (int i = 0; i < LANES; i++) begin
                    total++;
                    if (got[i] !== post(m_acc[i])) begin
                        bad++;
                        $display("FAIL rand_lane%0d job=%0d grp=%0d got=%0d required=%0d",
                                 i, j, g, got[i], post(m_acc[i]));
                    end
                end
                total++;
                if ({lst, dn} !== {2{g == ng - 1}}) begin
                    bad++; $display("FAIL rand_last job=%0d grp=%0d got=%b required=%b", j, g, {lst, dn}, {2{g == ng - 1}});
                end
            end
            total++;
            if (sat_flag !== m_sat) begin bad++; $display("FAIL rand_sat job=%0d got=%0b required=%0b", j, sat_flag, m_sat); end
        end
    endtask

`ifdef PSUM_ACC_RELU_EN
    task automatic test_relu();
        beat_t got;
        bit lst, dn;
        do_start(2, 1);
        feed('{-4, 2, 0, 0}, 1);
        feed('{-3, 3, 0, 0}, 0);
        take(got, lst, dn);
        total++;
        if (got[0] !== 0) begin bad++; $display("FAIL relu_lane0 got=%0d required=0", got[0]); end
        total++;
        if (got[1] !== 5) begin bad++; $display("FAIL relu_lane1 got=%0d required=5", got[1]); end
    endtask
`endif

    initial begin
        m_sat = 1'b0;
        test_reset();
        test_basic();
        test_saturation();
        test_backpressure();
        test_num_pass_zero();
        test_num_groups_zero();
        test_start_busy();
        test_reset_mid_job();
        test_random();
`ifdef PSUM_ACC_RELU_EN
        test_relu();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
